bu_ndiag_pe: RTL and testbench
==============================

Name: bu_ndiag_pe

Overview:
Parametrised non-diagonal boundary-unit processing element for the UKF systolic decomposition array. It streams a vector of element pairs and computes result = bias + sum(a_i * b_i) in signed fixed point. The datapath is a 3-stage pipeline (capture, multiply, accumulate/saturate) with explicit first/last vector framing and zero/overflow/underflow status. It replaces the single-product non-diagonal unit and supports variable width, Q-format and vector length.

Parameters:
DATA_W, 32, operand/result width (signed two's complement)
FRAC_W, 16, fractional bits of the Q format for operands, bias and result
MAX_LEN, 64, maximum elements per vector; accumulator guard bits = clog2(MAX_LEN)+1

Ports:
clock  in  1  single clock, rising edge
aclr_n  in  1  asynchronous active-low reset
clk_en  in  1  global enable; low freezes every register, outputs included
data_in_flag  in  1  element valid; sampled only when clk_en=1
first  in  1  marks first element of a vector; qualified by data_in_flag
last  in  1  marks last element of a vector; qualified by data_in_flag
dataa_mul  in  DATA_W  multiplicand a_i
datab_mul  in  DATA_W  multiplier b_i
data_b_accum  in  DATA_W  bias, sampled only with the first element
result  out  DATA_W  saturated dot product
data_available  out  1  result valid, one enabled-cycle pulse
zero  out  1  result == 0; valid with data_available
overflow  out  1  saturation occurred anywhere in the vector
underflow  out  1  some nonzero full-precision product scaled to 0
seq_err  out  1  one-cycle pulse on a framing error
elem_cnt  out  clog2(MAX_LEN+1)  element count of the emitted vector

Behaviour:
- Reset (aclr_n=0, async): all pipeline registers, accumulator and counter cleared. result=0, data_available=0, zero=0, overflow=0, underflow=0, seq_err=0, elem_cnt=0. Reset mid-vector abandons the vector; no output follows.
- Accept: an element is accepted on a rising edge with clk_en=1 and data_in_flag=1. With data_in_flag=0, that cycle is a bubble: the accumulator holds and the vector stays open.
- Pipeline: S1 registers a, b, bias and flags. S2 forms the 2*DATA_W signed product, arithmetic-shifts it right by FRAC_W (truncation toward minus infinity) and records product overflow/underflow. S3 adds the product into the accumulator (DATA_W+guard bits). On first, the accumulator loads bias + product.
- Latency: the last element accepted at edge N gives result/data_available/flags at edge N+3. Back-to-back vectors are allowed: first may follow last on the next cycle. Throughput is one element per cycle.
- Saturation: on emission, the accumulator is clamped to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and overflow=1 if clamped. A scaled product outside the accumulator range also sets overflow for that vector.
- Underflow: set if any product is nonzero before scaling and zero after scaling.
- Flags: overflow and underflow are per-vector sticky, cleared at that vector's first element, and presented with data_available.
- Framing FSM, states IDLE and ACCUM:
  - IDLE + first: go to ACCUM; first&last together emit a single-element vector and stay in IDLE.
  - IDLE + element without first: treated as first and seq_err pulses.
  - ACCUM + first: the open vector is discarded (no emission), seq_err pulses, and a new vector starts.
  - ACCUM + last: emit and return to IDLE.
  - ACCUM, element count reaches MAX_LEN without last: force emission, seq_err pulses, return to IDLE.
- clk_en=0: full stall, no state change; data_available stays asserted if it was already high.

Optional Feature:
BU_NDIAG_ROUND_EN: when defined, S2 adds 2^(FRAC_W-1) before the right shift (round half up); underflow then means the rounded result is 0 while the unscaled product is nonzero. When undefined, S2 truncates. Latency is identical in both builds.

Test Plan:
- Q16.16, bias 0x00010000, vector (0x00020000,0x00030000),(0x00040000,0x00050000) -> result 0x001B0000 three edges after last, data_available for one cycle, elem_cnt=2, all flags 0.
- a=b=0x7FFF0000, single element with first&last -> result 0x7FFFFFFF, overflow=1; a=0x80000000, b=0x7FFF0000 -> result 0x80000000, overflow=1.
- a=b=0x00000001, first&last, bias 0 -> result 0, zero=1, underflow=1.
- a=0x00008000, b=0x00000001 -> result 0x00000000 without BU_NDIAG_ROUND_EN, 0x00000001 with it.
- Framing:
  - Element, first (no last), then first again -> seq_err pulse; only the second vector is emitted.
  - MAX_LEN+1 elements with no last -> forced emission with elem_cnt=MAX_LEN and a seq_err pulse.
- Stall and reset:
  - clk_en low for 5 cycles inside a 4-element vector -> same result, emitted 3 enabled edges after last.
  - aclr_n pulsed low mid-vector -> all outputs 0 and no data_available until a new first.

Source files
------------

// File: rtl/bu_ndiag_pe.sv
// bu_ndiag_pe: non-diagonal boundary-unit processing element.
// Streams (a_i, b_i) pairs and produces result = bias + sum(a_i * b_i) in signed
// Q(DATA_W-FRAC_W).FRAC_W fixed point through a capture / multiply / accumulate
// pipeline, followed by a saturating output register (last element -> result in 3 edges).
// Optional build macro BU_NDIAG_ROUND_EN: round-half-up product scaling instead of
// truncation toward minus infinity.
module bu_ndiag_pe #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FRAC_W  = 16,
    parameter int unsigned MAX_LEN = 64,
    localparam int unsigned GUARD_W = $clog2(MAX_LEN) + 1,
    localparam int unsigned ACC_W   = DATA_W + GUARD_W,
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1)
) (
    input  logic              clock,
    input  logic              aclr_n,
    input  logic              clk_en,
    input  logic              data_in_flag,
    input  logic              first,
    input  logic              last,
    input  logic [DATA_W-1:0] dataa_mul,
    input  logic [DATA_W-1:0] datab_mul,
    input  logic [DATA_W-1:0] data_b_accum,
    output logic [DATA_W-1:0] result,
    output logic              data_available,
    output logic              zero,
    output logic              overflow,
    output logic              underflow,
    output logic              seq_err,
    output logic [CNT_W-1:0]  elem_cnt
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned EXT_W  = PROD_W + 1;  // headroom for the rounding add
    localparam logic [ACC_W-1:0]  ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0]  ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] RES_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] RES_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [0:0] {StIdle, StAccum} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, new_cnt;
    logic             accept, start, emit, frame_err;

    assign accept = clk_en & data_in_flag;

    // Framing state register: only accepted elements advance the frame
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= state_d;
            cnt_q   <= new_cnt;
        end
    end

    // Framing next state: any emission closes the vector
    always_comb begin
        state_d = emit ? StIdle : StAccum;
    end

    // Framing outputs: an element in IDLE always opens a vector; first in ACCUM restarts one
    always_comb begin
        start     = (state_q == StIdle) | first;
        new_cnt   = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
        emit      = last | (new_cnt == CNT_W'(MAX_LEN));
        frame_err = ((state_q == StIdle) & ~first) | ((state_q == StAccum) & first)
                  | (~last & (new_cnt == CNT_W'(MAX_LEN)));
    end

    // S1: capture operands and framing decisions
    logic                     s1_vld, s1_start, s1_emit;
    logic [CNT_W-1:0]         s1_cnt;
    logic signed [DATA_W-1:0] s1_a, s1_b;
    logic [DATA_W-1:0]        s1_bias;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_vld   <= 1'b0;
            s1_start <= 1'b0;
            s1_emit  <= 1'b0;
            s1_cnt   <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_bias  <= '0;
            seq_err  <= 1'b0;
        end else if (clk_en) begin
            s1_vld  <= data_in_flag;
            seq_err <= data_in_flag & frame_err;
            if (data_in_flag) begin
                s1_start <= start;
                s1_emit  <= emit;
                s1_cnt   <= new_cnt;
                s1_a     <= dataa_mul;
                s1_b     <= datab_mul;
                if (start) s1_bias <= data_b_accum;
            end
        end
    end

    // S2 datapath: full product, scale by FRAC_W, clamp into accumulator range
    logic signed [PROD_W-1:0] prod_full;
    logic signed [EXT_W-1:0]  prod_ext, prod_scaled;
    logic                     prod_in_range, prod_udf;
    logic [ACC_W-1:0]         prod_sat;

    always_comb begin
        prod_full = PROD_W'(s1_a) * PROD_W'(s1_b);
        prod_ext  = {prod_full[PROD_W-1], prod_full};
`ifdef BU_NDIAG_ROUND_EN
        prod_ext  = prod_ext + (EXT_W'(1) << (FRAC_W - 1));
`endif
        prod_scaled   = prod_ext >>> FRAC_W;
        prod_in_range = (&prod_scaled[EXT_W-1:ACC_W-1]) | ~(|prod_scaled[EXT_W-1:ACC_W-1]);
        prod_sat      = prod_in_range ? prod_scaled[ACC_W-1:0]
                      : (prod_scaled[EXT_W-1] ? ACC_MIN : ACC_MAX);
        prod_udf      = (prod_full != '0) && (prod_scaled == '0);
    end

    // S2: register scaled product and its status
    logic              s2_vld, s2_start, s2_emit, s2_ovf, s2_udf;
    logic [CNT_W-1:0]  s2_cnt;
    logic [DATA_W-1:0] s2_bias;
    logic [ACC_W-1:0]  s2_prod;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            s2_vld   <= 1'b0;
            s2_start <= 1'b0;
            s2_emit  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_udf   <= 1'b0;
            s2_cnt   <= '0;
            s2_bias  <= '0;
            s2_prod  <= '0;
        end else if (clk_en) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_start <= s1_start;
                s2_emit  <= s1_emit;
                s2_ovf   <= ~prod_in_range;
                s2_udf   <= prod_udf;
                s2_cnt   <= s1_cnt;
                s2_bias  <= s1_bias;
                s2_prod  <= prod_sat;
            end
        end
    end

    // S3 datapath: saturating accumulate, bias load on the first element
    logic [ACC_W-1:0] acc_q, acc_base, acc_d;
    logic [ACC_W:0]   acc_sum;
    logic             acc_ok, ovf_q, ovf_d, udf_q, udf_d;

    always_comb begin
        acc_base = s2_start ? {{GUARD_W{s2_bias[DATA_W-1]}}, s2_bias} : acc_q;
        acc_sum  = {acc_base[ACC_W-1], acc_base} + {s2_prod[ACC_W-1], s2_prod};
        acc_ok   = (acc_sum[ACC_W] == acc_sum[ACC_W-1]);
        acc_d    = acc_ok ? acc_sum[ACC_W-1:0] : (acc_sum[ACC_W] ? ACC_MIN : ACC_MAX);
        ovf_d    = (~s2_start & ovf_q) | s2_ovf | ~acc_ok;
        udf_d    = (~s2_start & udf_q) | s2_udf;
    end

    // S3: accumulator and per-vector sticky status
    logic             s3_emit;
    logic [CNT_W-1:0] s3_cnt;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            s3_emit <= 1'b0;
            s3_cnt  <= '0;
        end else if (clk_en) begin
            s3_emit <= s2_vld & s2_emit;
            if (s2_vld) begin
                acc_q  <= acc_d;
                ovf_q  <= ovf_d;
                udf_q  <= udf_d;
                s3_cnt <= s2_cnt;
            end
        end
    end

    // Output clamp of the accumulator to DATA_W
    logic              res_in_range;
    logic [DATA_W-1:0] res_sat;

    always_comb begin
        res_in_range = (&acc_q[ACC_W-1:DATA_W-1]) | ~(|acc_q[ACC_W-1:DATA_W-1]);
        res_sat      = res_in_range ? acc_q[DATA_W-1:0] : (acc_q[ACC_W-1] ? RES_MIN : RES_MAX);
    end

    // Output register: result and flags held between emissions
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            result         <= '0;
            data_available <= 1'b0;
            zero           <= 1'b0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            elem_cnt       <= '0;
        end else if (clk_en) begin
            data_available <= s3_emit;
            if (s3_emit) begin
                result    <= res_sat;
                zero      <= (res_sat == '0);
                overflow  <= ovf_q | ~res_in_range;
                underflow <= udf_q;
                elem_cnt  <= s3_cnt;
            end
        end
    end

endmodule

// File: tb/tb_bu_ndiag_pe.sv
// Directed self-checking bench for bu_ndiag_pe (default parameters, Q16.16).
module tb_bu_ndiag_pe;

    logic        clock = 1'b0;
    logic        aclr_n = 1'b1;
    logic        clk_en = 1'b1;
    logic        data_in_flag = 1'b0;
    logic        first = 1'b0;
    logic        last = 1'b0;
    logic [31:0] dataa_mul = '0;
    logic [31:0] datab_mul = '0;
    logic [31:0] data_b_accum = '0;
    logic [31:0] result;
    logic        data_available, zero, overflow, underflow, seq_err;
    logic [6:0]  elem_cnt;

    int checks = 0;
    int errors = 0;

    // Activity monitor filled in by tick(): counts enabled-edge pulses
    int          da_cnt = 0;
    int          se_cnt = 0;
    logic [31:0] first_res, last_res;
    logic [6:0]  first_cnt, last_cnt;

    always #5 clock = ~clock;

    bu_ndiag_pe dut (
        .clock         (clock),
        .aclr_n        (aclr_n),
        .clk_en        (clk_en),
        .data_in_flag  (data_in_flag),
        .first         (first),
        .last          (last),
        .dataa_mul     (dataa_mul),
        .datab_mul     (datab_mul),
        .data_b_accum  (data_b_accum),
        .result        (result),
        .data_available(data_available),
        .zero          (zero),
        .overflow      (overflow),
        .underflow     (underflow),
        .seq_err       (seq_err),
        .elem_cnt      (elem_cnt)
    );

    task automatic tick();
        logic en;
        @(posedge clock);
        en = clk_en;
        #1;
        if (en && data_available) begin
            da_cnt++;
            last_res = result;
            last_cnt = elem_cnt;
            if (da_cnt == 1) begin
                first_res = result;
                first_cnt = elem_cnt;
            end
        end
        if (en && seq_err) se_cnt++;
    endtask

    task automatic send(input logic f, input logic l, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] bias);
        first = f; last = l; dataa_mul = a; datab_mul = b; data_b_accum = bias;
        data_in_flag = 1'b1;
        tick();
        data_in_flag = 1'b0; first = 1'b0; last = 1'b0;
    endtask

    task automatic wait_da(output bit got);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if (data_available) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        #3 aclr_n = 1'b0;
        #4;
        checks++;
        if ({result, data_available, zero, overflow, underflow, seq_err, elem_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got res=%h da=%b z=%b o=%b u=%b se=%b cnt=%0d want all 0",
                     result, data_available, zero, overflow, underflow, seq_err, elem_cnt);
        end
        #10 aclr_n = 1'b1;
        tick(); tick();
    endtask

    task automatic test_basic();
        send(1, 0, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        send(0, 1, 32'h0004_0000, 32'h0005_0000, 32'hDEAD_0000);
        tick(); tick();
        checks++;
        if (data_available !== 1'b0) begin
            errors++; $display("FAIL basic_early_da got %b want 0", data_available);
        end
        tick();
        checks++;
        if (data_available !== 1'b1 || result !== 32'h001B_0000) begin
            errors++;
            $display("FAIL basic_result got da=%b res=%h want da=1 res=001b0000",
                     data_available, result);
        end
        checks++;
        if (elem_cnt !== 7'd2 || {zero, overflow, underflow} !== 3'b000) begin
            errors++;
            $display("FAIL basic_status got cnt=%0d zou=%b%b%b want cnt=2 zou=000",
                     elem_cnt, zero, overflow, underflow);
        end
        tick();
        checks++;
        if (data_available !== 1'b0) begin
            errors++; $display("FAIL basic_pulse got da=%b want 0", data_available);
        end
    endtask

    task automatic test_saturation();
        bit got;
        send(1, 1, 32'h7FFF_0000, 32'h7FFF_0000, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos got da=%b res=%h ovf=%b want 1 7fffffff 1",
                     got, result, overflow);
        end
        send(1, 1, 32'h8000_0000, 32'h7FFF_0000, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sat_neg got da=%b res=%h ovf=%b z=%b want 1 80000000 1 0",
                     got, result, overflow, zero);
        end
    endtask

    task automatic test_back_to_back();
        send(1, 0, 32'h0001_0000, 32'h0002_0000, 32'h0);
        send(0, 1, 32'h0003_0000, 32'h0001_0000, 32'h0);
        send(1, 1, 32'hFFFF_0000, 32'h0003_0000, 32'h0001_0000);
        tick();
        checks++;
        if (data_available !== 1'b0) begin
            errors++; $display("FAIL b2b_early_da got %b want 0", data_available);
        end
        tick();
        checks++;
        if (data_available !== 1'b1 || result !== 32'h0005_0000 || elem_cnt !== 7'd2
            || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_vec1 got da=%b res=%h cnt=%0d ovf=%b want 1 00050000 2 0",
                     data_available, result, elem_cnt, overflow);
        end
        tick();
        checks++;
        if (data_available !== 1'b1 || result !== 32'hFFFE_0000 || elem_cnt !== 7'd1
            || zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_vec2 got da=%b res=%h cnt=%0d z=%b want 1 fffe0000 1 0",
                     data_available, result, elem_cnt, zero);
        end
        tick();
        checks++;
        if (data_available !== 1'b0) begin
            errors++; $display("FAIL b2b_end got da=%b want 0", data_available);
        end
    endtask

    task automatic test_underflow();
        bit got;
        send(1, 1, 32'h1, 32'h1, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== 32'h0 || zero !== 1'b1 || underflow !== 1'b1
            || overflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow got da=%b res=%h z=%b u=%b o=%b want 1 0 1 1 0",
                     got, result, zero, underflow, overflow);
        end
    endtask

    task automatic test_round();
        bit got;
        logic [31:0] exp_res;
        logic        exp_udf;
`ifdef BU_NDIAG_ROUND_EN
        exp_res = 32'h1; exp_udf = 1'b0;
`else
        exp_res = 32'h0; exp_udf = 1'b1;
`endif
        send(1, 1, 32'h0000_8000, 32'h1, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== exp_res || underflow !== exp_udf) begin
            errors++;
            $display("FAIL round_half got da=%b res=%h u=%b want 1 %h %b",
                     got, result, underflow, exp_res, exp_udf);
        end
`ifdef BU_NDIAG_ROUND_EN
        exp_res = 32'h0; exp_udf = 1'b1;
`else
        exp_res = 32'hFFFF_FFFF; exp_udf = 1'b0;
`endif
        send(1, 1, 32'hFFFF_FFFF, 32'h1, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== exp_res || underflow !== exp_udf) begin
            errors++;
            $display("FAIL round_neg got da=%b res=%h u=%b want 1 %h %b",
                     got, result, underflow, exp_res, exp_udf);
        end
    endtask

    task automatic test_discard();
        da_cnt = 0; se_cnt = 0;
        send(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0005_0000);
        send(1, 1, 32'h0002_0000, 32'h0002_0000, 32'h0003_0000);
        checks++;
        if (seq_err !== 1'b1) begin
            errors++; $display("FAIL discard_seq_err got %b want 1", seq_err);
        end
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (da_cnt != 1 || se_cnt != 1 || last_res !== 32'h0007_0000 || last_cnt !== 7'd1) begin
            errors++;
            $display("FAIL discard_emit got pulses=%0d seqerr=%0d res=%h cnt=%0d want 1 1 00070000 1",
                     da_cnt, se_cnt, last_res, last_cnt);
        end
    endtask

    task automatic test_maxlen();
        da_cnt = 0; se_cnt = 0;
        for (int i = 0; i < 65; i++) send(i == 0, 0, 32'h0001_0000, 32'h0001_0000, 32'h0);
        send(0, 1, 32'h0, 32'h0, 32'h0);
        for (int i = 0; i < 7; i++) tick();
        checks++;
        if (da_cnt != 2 || se_cnt != 2) begin
            errors++;
            $display("FAIL maxlen_pulses got da=%0d seqerr=%0d want 2 2", da_cnt, se_cnt);
        end
        checks++;
        if (first_res !== 32'h0040_0000 || first_cnt !== 7'd64) begin
            errors++;
            $display("FAIL maxlen_forced got res=%h cnt=%0d want 00400000 64", first_res, first_cnt);
        end
        checks++;
        if (last_res !== 32'h0001_0000 || last_cnt !== 7'd2) begin
            errors++;
            $display("FAIL maxlen_tail got res=%h cnt=%0d want 00010000 2", last_res, last_cnt);
        end
    endtask

    task automatic test_stall();
        da_cnt = 0;
        send(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000);
        send(0, 0, 32'h0002_0000, 32'h0002_0000, 32'h0);
        clk_en = 1'b0;
        data_in_flag = 1'b1; first = 1'b1; last = 1'b1; dataa_mul = 32'h7FFF_0000;
        for (int i = 0; i < 5; i++) tick();
        data_in_flag = 1'b0; first = 1'b0; last = 1'b0;
        clk_en = 1'b1;
        send(0, 0, 32'h0003_0000, 32'h0003_0000, 32'h0);
        send(0, 1, 32'h0004_0000, 32'h0004_0000, 32'h0);
        tick(); tick();
        checks++;
        if (data_available !== 1'b0) begin
            errors++; $display("FAIL stall_early_da got %b want 0", data_available);
        end
        tick();
        checks++;
        if (data_available !== 1'b1 || result !== 32'h0020_0000 || elem_cnt !== 7'd4) begin
            errors++;
            $display("FAIL stall_result got da=%b res=%h cnt=%0d want 1 00200000 4",
                     data_available, result, elem_cnt);
        end
        clk_en = 1'b0;
        tick(); tick();
        checks++;
        if (data_available !== 1'b1 || result !== 32'h0020_0000) begin
            errors++;
            $display("FAIL stall_hold got da=%b res=%h want 1 00200000", data_available, result);
        end
        clk_en = 1'b1;
        tick();
        checks++;
        if (data_available !== 1'b0 || da_cnt != 1) begin
            errors++;
            $display("FAIL stall_release got da=%b pulses=%0d want 0 1", data_available, da_cnt);
        end
    endtask

    task automatic test_async_reset();
        bit got;
        send(1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        send(0, 0, 32'h0002_0000, 32'h0001_0000, 32'h0);
        #2 aclr_n = 1'b0;
        #1;
        checks++;
        if ({result, data_available, zero, overflow, underflow, seq_err, elem_cnt} !== '0) begin
            errors++;
            $display("FAIL areset_outputs got res=%h da=%b z=%b o=%b u=%b se=%b cnt=%0d want 0",
                     result, data_available, zero, overflow, underflow, seq_err, elem_cnt);
        end
        #8 aclr_n = 1'b1;
        da_cnt = 0;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (da_cnt != 0 || result !== 32'h0) begin
            errors++;
            $display("FAIL areset_quiet got pulses=%0d res=%h want 0 0", da_cnt, result);
        end
        send(1, 1, 32'h0003_0000, 32'h0002_0000, 32'h0);
        wait_da(got);
        checks++;
        if (!got || result !== 32'h0006_0000 || elem_cnt !== 7'd1) begin
            errors++;
            $display("FAIL areset_next got da=%b res=%h cnt=%0d want 1 00060000 1",
                     got, result, elem_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_back_to_back();
        test_underflow();
        test_round();
        test_discard();
        test_maxlen();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
